// File: rtl/serial_block_adder_pkg.sv
// serial_block_adder_pkg
// Shared definitions for the serial block adder:
//   - state_t   : controller states (IDLE, RUN, DONE), 2 bits
//   - blocks()  : number of slices for a given operand/slice width
//   - width_ok(): legality test used by the top-level elaboration check
//                 (WIDTH must be a non-zero multiple of BLOCK)
// Optional feature macro used by the top: SERIAL_BLOCK_ADDER_SUBTRACT_EN
package serial_block_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int blocks(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit width_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/serial_block_adder_block_lookahead.sv
// block_lookahead
// Purely combinational BLOCK-bit carry-lookahead adder slice.
// Ports:
//   a, b      in  BLOCK  slice operands
//   cin       in  1      carry into bit 0 of the slice
//   s         out BLOCK  slice sum
//   cout      out 1      carry out of the slice MSB
//   c_msb_in  out 1      carry into the slice MSB (for signed overflow)
module block_lookahead #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the fully expanded lookahead sum-of-products:
    //   c[i] = cin&p[0]..p[i-1]  |  OR_j ( g[j] & p[j+1]..p[i-1] )
    // so no carry depends on another carry (no ripple chain).
    always_comb begin
        logic term;
        logic acc;
        c = '0;
        for (int i = 0; i <= BLOCK; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign s        = p ^ c[BLOCK-1:0];
    assign cout     = c[BLOCK];
    assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/serial_block_adder.sv
// serial_block_adder
// Multi-cycle WIDTH-bit adder that processes one BLOCK-bit slice per clock,
// LSB slice first, with the inter-slice carry held in a register.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start_valid/ready   operand handshake (alpha, beta, carry_in[, subtract])
//   result_valid/ready  result handshake (sum, carry_out, overflow)
//   busy                high while slices are being processed
//   state_o             controller state for observation
// Optional feature: define SERIAL_BLOCK_ADDER_SUBTRACT_EN to add the
// 'subtract' input; subtract=1 computes alpha + ~beta + 1.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. start_ready is high only in IDLE, result_valid only in DONE, so an
// accept never overlaps a pending result. Outputs hold until transferred.
module serial_block_adder
    import serial_block_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] alpha,
    input  logic [WIDTH-1:0] beta,
    input  logic             carry_in,
`ifdef SERIAL_BLOCK_ADDER_SUBTRACT_EN
    input  logic             subtract,
`endif
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic [1:0]       state_o
);

    localparam int NBLK = blocks(WIDTH, BLOCK);
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

    if (!width_ok(WIDTH, BLOCK)) begin : g_bad_width
        $error("serial_block_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             sub_w;
    logic [BLOCK-1:0] slice_a;
    logic [BLOCK-1:0] slice_b;
    logic [BLOCK-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;

`ifdef SERIAL_BLOCK_ADDER_SUBTRACT_EN
    assign sub_w = subtract;
`else
    assign sub_w = 1'b0;
`endif

    assign slice_a = a_q[int'(idx_q) * BLOCK +: BLOCK];
    assign slice_b = b_q[int'(idx_q) * BLOCK +: BLOCK];

    block_lookahead #(.BLOCK(BLOCK)) u_block (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (carry_q),
        .s        (slice_s),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = alpha;
                    // Subtraction is folded into the operands at capture:
                    // invert beta and force the initial carry to 1.
                    b_d     = sub_w ? ~beta : beta;
                    carry_d = sub_w ? 1'b1 : carry_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * BLOCK +: BLOCK] = slice_s;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(NBLK - 1)) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q == RUN);
    assign sum          = sum_q;
    assign carry_out    = cout_q;
    assign overflow     = ovf_q;
    assign state_o      = state_q;

endmodule

// File: doc/serial_block_adder.md
Name: serial_block_adder

Overview:
Parametrised multi-cycle adder that adds two WIDTH-bit operands one BLOCK-bit slice per clock, starting from the least-significant slice. Each slice is a carry-lookahead block, and the carry between slices is registered. It generalises the fixed 4-bit ripple and lookahead adders to arbitrary width, trading latency for area. Valid/ready handshakes let it sit between operand sources, such as switch/button capture logic, and result consumers, such as the seven-segment display path.

Parameters:
- WIDTH, 16: operand and sum width in bits. Must be a multiple of BLOCK and at least BLOCK.
- BLOCK, 4: slice width added per cycle.
- NBLK (localparam), WIDTH/BLOCK: number of slices, equal to the RUN cycle count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start_valid  in  1  operands and carry_in are presented.
- start_ready  out  1  block can accept an operation.
- alpha  in  WIDTH  operand A.
- beta  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0.
- result_valid  out  1  sum, carry_out and overflow are valid.
- result_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of the MSB.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN.

Behaviour:
- Clock and reset:
  - One clock domain; reset is synchronous and active-high.
  - reset has priority over every other event, including mid-RUN and in DONE.
  - The state machine is reset to IDLE.
  - Outputs at reset: start_ready=1, result_valid=0, busy=0, sum=0, carry_out=0, overflow=0. Internal operand registers, slice index and carry are cleared.
- IDLE:
  - start_ready=1.
  - If start_valid=1 at the edge, capture alpha, beta and carry_in, set index=0 and carry=carry_in, and go to RUN.
  - Inputs are ignored whenever start_ready=0.
- RUN:
  - busy=1, start_ready=0.
  - Each edge computes slice[index] = a_slice + b_slice + carry through the lookahead block, writes it into sum[index*BLOCK +: BLOCK], updates carry, and increments index.
  - On the edge that processes index=NBLK-1:
    - Latch carry_out.
    - Latch overflow from that slice's internal MSB carries.
    - Go to DONE.
- DONE:
  - result_valid=1, busy=0, start_ready=0.
  - sum, carry_out and overflow hold stable until the handshake completes.
  - If result_ready=1 at the edge, go to IDLE. sum, carry_out and overflow keep their values; only result_valid drops.
- Latency: for acceptance at edge E0, result_valid is high after edge E0+NBLK. With NBLK=1, DONE is entered one edge after acceptance.
- Minimum throughput: one operation per NBLK+2 cycles. There is no overlap of accept with DONE.
- Arithmetic: unsigned modulo 2^WIDTH. carry_out is the full-width carry; overflow is the two's-complement interpretation.
- Partial sum bits: sum bits of unprocessed slices are undefined-but-stable while busy=1, and must not be used while result_valid=0.

Optional Feature:
- Macro: SERIAL_BLOCK_ADDER_SUBTRACT_EN.
- When defined:
  - Adds input port subtract (1 bit), captured with the operands at acceptance.
  - subtract=1 computes alpha - beta, implemented as alpha + ~beta + 1. carry_in is ignored and forced to 1.
  - carry_out=1 means no borrow.
  - overflow follows the same rule as for addition.
- When undefined: no subtract port, and behaviour is pure addition as above.

Decomposition:
- Package serial_block_adder_pkg holds:
  - the state_t enum {IDLE, RUN, DONE}, 2 bits;
  - the function blocks(width, block) returning width/block;
  - an elaboration check that fails when WIDTH % BLOCK != 0.
- Sub-module block_lookahead is parametrised by BLOCK.
  - Inputs: a[BLOCK], b[BLOCK], cin.
  - Outputs: s[BLOCK], cout, c_msb_in (carry into the slice MSB).
  - Implementation: generate/propagate terms with full lookahead carry expressions. It is purely combinational and instantiated once.

Test Plan:
1. WIDTH=16, BLOCK=4: accept 0xFFFF + 0x0001, carry_in=0 → result_valid exactly 4 edges after accept; sum=0x0000, carry_out=1, overflow=0.
2. 0x1234 + 0x4321, carry_in=1 → sum=0x5556, carry_out=0. Then 0x7FFF + 0x0001 → sum=0x8000, overflow=1, carry_out=0.
3. Backpressure: hold result_ready=0 for 10 cycles in DONE → sum, carry_out and overflow unchanged, start_ready=0, and a start_valid pulse is ignored. Raise result_ready → IDLE next edge, start_ready=1.
4. Reset asserted on the 2nd RUN cycle → next edge: IDLE, busy=0, result_valid=0, sum=0. A following operation 0x0003 + 0x0004 → sum=0x0007.
5. With SERIAL_BLOCK_ADDER_SUBTRACT_EN: 0x0005 - 0x0007 → sum=0xFFFE, carry_out=0. 0x0007 - 0x0005 → sum=0x0002, carry_out=1.
6. WIDTH=8, BLOCK=8 (NBLK=1): 0xC8 + 0x64 → sum=0x2C, carry_out=1, result_valid 1 edge after accept. WIDTH=12, BLOCK=8 → elaboration error.
